// File: rtl/wb_commit_tracer.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_tracer
// Brief    : Passive writeback observer; timestamps retiring instructions into
//            a show-ahead FIFO and keeps retired/cycle/dropped counters.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_tracer #(
  parameter int DEPTH      = 16,
  parameter int XLEN       = 32,
  parameter bit CAPTURE_X0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [XLEN-1:0]            wb_pc,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [4:0]                 rd_rd,
  output logic [XLEN-1:0]            rd_data,
  output logic [31:0]                rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [31:0]                retired,
  output logic [15:0]                dropped,
  output logic [31:0]                cycle
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [31:0]     r_mem_cyc  [DEPTH];

  logic [c_aw-1:0] r_wptr, r_rptr;
  logic [c_cw-1:0] r_count;
  logic [XLEN-1:0] r_head_pc, r_head_data;
  logic [4:0]      r_head_rd;
  logic [31:0]     r_head_cyc;
  logic            r_overflow;
  logic [15:0]     r_dropped;
  logic [31:0]     r_retired, r_cycle;

  logic            w_cap, w_full, w_pop, w_push, w_drop;
  logic [c_aw-1:0] w_rptr_nxt;
  logic [c_cw-1:0] w_count_nxt;

  always_comb begin
    w_cap      = wb_valid & (CAPTURE_X0 | (wb_rd != 5'd0));
    w_full     = (r_count == c_cw'(DEPTH));
    w_pop      = (r_count != '0) & rd_ready;
    w_push     = w_cap & (~w_full | w_pop);
    w_drop     = w_cap & w_full & ~w_pop;
    w_rptr_nxt = w_pop ? r_rptr + c_aw'(1) : r_rptr;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cw'(1);
      2'b01:   w_count_nxt = r_count - c_cw'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= wb_pc;
      r_mem_rd[r_wptr]   <= wb_rd;
      r_mem_data[r_wptr] <= wb_data;
      r_mem_cyc[r_wptr]  <= r_cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_aw'(1);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Head registers preload the next head; a push into that same slot is forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_pc   <= '0;
      r_head_rd   <= '0;
      r_head_data <= '0;
      r_head_cyc  <= '0;
    end else if (w_count_nxt != '0) begin
      if (w_push && (r_wptr == w_rptr_nxt)) begin
        r_head_pc   <= wb_pc;
        r_head_rd   <= wb_rd;
        r_head_data <= wb_data;
        r_head_cyc  <= r_cycle;
      end else begin
        r_head_pc   <= r_mem_pc[w_rptr_nxt];
        r_head_rd   <= r_mem_rd[w_rptr_nxt];
        r_head_data <= r_mem_data[w_rptr_nxt];
        r_head_cyc  <= r_mem_cyc[w_rptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle    <= '0;
      r_retired  <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (wb_valid) r_retired <= r_retired + 32'd1;
      // A drop in the same cycle as a clear leaves exactly that one drop recorded.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr_overflow)             r_dropped <= 16'd1;
        else if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
        r_dropped  <= '0;
      end
    end
  end

  assign rd_valid = (r_count != '0);
  assign rd_pc    = r_head_pc;
  assign rd_rd    = r_head_rd;
  assign rd_data  = r_head_data;
  assign rd_cycle = r_head_cyc;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign retired  = r_retired;
  assign dropped  = r_dropped;
  assign cycle    = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_tracer
// Brief    : Directed self-checking bench for wb_commit_tracer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_tracer;

  logic        clk = 1'b0;
  logic        reset, wb_valid, rd_ready, clr_overflow;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        rd_valid, overflow;
  logic [31:0] rd_pc, rd_data, rd_cycle, retired, cycle;
  logic [4:0]  rd_rd;
  logic [4:0]  count;
  logic [15:0] dropped;

  logic        z_rd_valid, z_overflow;
  logic [31:0] z_rd_pc, z_rd_data, z_rd_cycle, z_retired, z_cycle;
  logic [4:0]  z_rd_rd;
  logic [4:0]  z_count;
  logic [15:0] z_dropped;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_commit_tracer #(.DEPTH(16), .XLEN(32), .CAPTURE_X0(1'b1)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_data(wb_data), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_rd(rd_rd), .rd_data(rd_data), .rd_cycle(rd_cycle), .count(count),
    .overflow(overflow), .clr_overflow(clr_overflow), .retired(retired),
    .dropped(dropped), .cycle(cycle)
  );

  wb_commit_tracer #(.DEPTH(16), .XLEN(32), .CAPTURE_X0(1'b0)) dut_nox0 (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_data(wb_data), .rd_ready(rd_ready), .rd_valid(z_rd_valid), .rd_pc(z_rd_pc),
    .rd_rd(z_rd_rd), .rd_data(z_rd_data), .rd_cycle(z_rd_cycle), .count(z_count),
    .overflow(z_overflow), .clr_overflow(clr_overflow), .retired(z_retired),
    .dropped(z_dropped), .cycle(z_cycle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
    wb_pc = '0; wb_rd = '0; wb_data = '0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_retired", retired, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_rd_pc", rd_pc, 0);
    reset = 1'b0;

    // idle: cycle counts 0..4 over the first five cycles after release
    repeat (4) tick();
    chk("idle_cycle", cycle, 4);
    chk("idle_valid", rd_valid, 0);
    chk("idle_count", count, 0);

    // single commit captured at cycle 3
    do_reset();
    repeat (3) tick();
    chk("pre_commit_cycle", cycle, 3);
    commit(32'h10, 5'd5, 32'hA5);
    chk("one_valid", rd_valid, 1);
    chk("one_pc", rd_pc, 32'h10);
    chk("one_rd", rd_rd, 5);
    chk("one_data", rd_data, 32'hA5);
    chk("one_cycle", rd_cycle, 3);
    chk("one_retired", retired, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("one_pop_valid", rd_valid, 0);
    chk("one_pop_count", count, 0);
    chk("one_hold_pc", rd_pc, 32'h10);

    // empty FIFO: capture with rd_ready high pushes only
    rd_ready = 1'b1;
    commit(32'h20, 5'd6, 32'h66);
    rd_ready = 1'b0;
    chk("nobypass_count", count, 1);
    chk("nobypass_pc", rd_pc, 32'h20);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // overflow: 18 back-to-back commits into 16 entries
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      commit(32'(i * 4), 5'((i % 31) + 1), 32'(i + 256));
      if (i < 16) exp_q.push_back(32'(i * 4));
    end
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_dropped", dropped, 2);
    chk("ovf_retired", retired, 18);
    chk("ovf_head", rd_pc, 0);

    // full with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      chk("pp_head", rd_pc, exp_q.pop_front());
      rd_ready = 1'b1;
      commit(32'h100 + 32'(k * 4), 5'd9, 32'(k));
      rd_ready = 1'b0;
      exp_q.push_back(32'h100 + 32'(k * 4));
    end
    chk("pp_count", count, 16);
    chk("pp_dropped", dropped, 2);
    for (int k = 0; k < 16; k++) begin
      chk("drain_pc", rd_pc, exp_q.pop_front());
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    chk("drain_empty", rd_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);

    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_dropped", dropped, 0);

    // clear coinciding with a drop: the drop wins
    for (int i = 0; i < 16; i++) commit(32'(i), 5'd1, 32'(i));
    chk("refill_ovf", overflow, 0);
    clr_overflow = 1'b1;
    commit(32'hDEAD, 5'd2, 32'h0);
    clr_overflow = 1'b0;
    chk("clrdrop_ovf", overflow, 1);
    chk("clrdrop_dropped", dropped, 1);
    chk("clrdrop_count", count, 16);

    // reset mid-operation with count=9, overflow=1
    rd_ready = 1'b1; repeat (7) tick(); rd_ready = 1'b0;
    chk("mid_count", count, 9);
    chk("mid_head", rd_pc, 7);
    do_reset();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_dropped", dropped, 0);
    chk("mid_rst_cycle", cycle, 0);
    chk("mid_rst_retired", retired, 0);

    // CAPTURE_X0=0: rd=0 commits counted but not captured
    commit(32'h200, 5'd0, 32'h1);
    commit(32'h204, 5'd3, 32'h2);
    commit(32'h208, 5'd0, 32'h3);
    commit(32'h20C, 5'd7, 32'h4);
    chk("nox0_retired", z_retired, 4);
    chk("nox0_count", z_count, 2);
    chk("x0_count", count, 4);
    chk("nox0_rd0", z_rd_rd, 3);
    chk("nox0_pc0", z_rd_pc, 32'h204);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("nox0_rd1", z_rd_rd, 7);
    chk("nox0_data1", z_rd_data, 4);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("nox0_empty", z_rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_commit_tracer.md
Name: wb_commit_tracer

Overview:
- Passive observer on the Full_Pipeline writeback stage.
- Every retiring instruction (pc, rd, result) is captured with a cycle timestamp into a show-ahead FIFO.
- The FIFO is drained by a valid/ready reader: a bench scoreboard or a debug port.
- Keeps retired-instruction, cycle and dropped-event counters, so runs can be checked by content, not only by waveform.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- XLEN, 32, width of writeback data and PC.
- CAPTURE_X0, 1. When 1, commits with rd=0 (stores, branches) are captured. When 0, they are counted but not captured.

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- wb_valid  input  1  an instruction retires this cycle
- wb_pc  input  XLEN  PC of the retiring instruction
- wb_rd  input  5  destination register index
- wb_data  input  XLEN  value written to wb_rd
- rd_ready  input  1  reader accepts the head entry
- rd_valid  output  1  head entry available
- rd_pc  output  XLEN  head entry PC
- rd_rd  output  5  head entry rd
- rd_data  output  XLEN  head entry data
- rd_cycle  output  32  head entry timestamp
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: at least one capture was dropped
- clr_overflow  input  1  clears overflow and dropped
- retired  output  32  total commits seen (wb_valid pulses)
- dropped  output  16  captures lost to a full FIFO, saturating
- cycle  output  32  free-running cycle counter

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: while reset=1 at a rising edge, the following are all zero: FIFO pointers, count, rd_valid, rd_* head outputs, overflow, retired, dropped, cycle.
- Reset mid-operation: flushes all entries, with no partial pop.
- cycle: equals 0 in the first cycle after reset deasserts, then +1 per clock; wraps 0xFFFFFFFF -> 0.
- retired: +1 on every wb_valid=1 cycle, regardless of rd, CAPTURE_X0 or FIFO state; wraps at 32 bits.
- Capture request: cap = wb_valid & (CAPTURE_X0 | wb_rd != 0).
- Stored entry: {wb_pc, wb_rd, wb_data, cycle}, with cycle sampled in the capture cycle.
- pop = rd_valid & rd_ready.
- push = cap & (count < DEPTH | pop). When full, a same-cycle pop frees the slot, so push and pop both occur and count is unchanged.
- Dropped capture: cap & count==DEPTH & !pop. The entry is discarded, overflow <= 1 and dropped <= dropped + 1, saturating at 0xFFFF.
- clr_overflow: clears overflow and dropped at the next edge. If a drop occurs in the same cycle, the drop wins: overflow=1 and dropped=1.
- FIFO is show-ahead:
  - rd_valid = (count != 0); rd_* always show the head entry.
  - A pushed entry becomes visible one cycle after the push edge (write-to-read latency 1).
- Empty: cap together with rd_ready=1 pushes only; there is no bypass to rd_* in the same cycle.
- Pointers: wrap modulo DEPTH. count +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Head outputs when count==0: rd_* hold their last value; rd_valid=0 is authoritative.
- Inputs are sampled only on clk edges; wb_* are don't-care when wb_valid=0.
- Ordering: entries leave in strict capture order; no reordering, no duplication.

Test Plan:
- Reset then idle 5 cycles -> cycle=4 in the fifth cycle after release; rd_valid=0; count=0; retired=0.
- Single commit, pc=0x10, rd=5, data=0xA5, captured at cycle=3, with rd_ready=0 -> next cycle rd_valid=1, rd_pc=0x10, rd_rd=5, rd_data=0xA5, rd_cycle=3. Then one rd_ready pulse -> rd_valid=0, count=0.
- Back-to-back overflow: DEPTH=16, 18 commits (pc=0,4,...,0x44), rd_ready=0 -> count=16, overflow=1, dropped=2, retired=18. Draining returns pc 0x00..0x3C in order.
- Full with simultaneous push and pop for 4 cycles -> count stays 16, dropped unchanged. Drained sequence has the 4 oldest removed and the 4 new entries at the tail.
- CAPTURE_X0=0: commits with rd=0,3,0,7 -> retired=4, count=2, drained rd sequence 3,7.
- Reset asserted with count=9 and overflow=1 -> next cycle count=0, rd_valid=0, overflow=0, cycle=0. clr_overflow coinciding with a drop -> overflow=1, dropped=1.
